// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame FSM states,
// parity selection and line-level bit constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic ONE  = 1'b1;
    localparam logic ZERO = 1'b0;

endpackage

// File: rtl/err_sat_counter.sv
// Saturating error counter; a clear in the same cycle
// as an increment leaves the counter at zero.
module err_sat_counter
    import uart_rx_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_cnt <= '0;
        end else if (clr) begin
            o_cnt <= '0;
        end else if (inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_frame_check.sv
// UART receive frame checker: start, data with running
// parity, optional parity bit and one or two stop bits.
module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Bit_Valid,
    input  logic                  Sampled_Bit,
    input  logic                  Frame_Abort,
    input  logic                  Par_EN,
    input  logic                  Par_Type,
    input  logic                  Stop_2,
    input  logic                  Cnt_Clr,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_Valid,
    output logic                  Start_Err,
    output logic                  Parity_Err,
    output logic                  Stop_Err,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  Err_Cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e             r_state;
    rx_state_e             w_state_n;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_acc;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_stop_2;
    logic                  r_stop_idx;

    logic w_strobe;
    logic w_start;
    logic w_false;
    logic w_end;
    logic w_stop_err_n;
    logic w_good;
    logic w_inc;

    // An abort swallows a coincident strobe entirely.
    assign w_strobe = Bit_Valid & ~Frame_Abort;

    always_comb begin
        w_state_n    = r_state;
        w_start      = 1'b0;
        w_false      = 1'b0;
        w_end        = 1'b0;
        w_stop_err_n = Stop_Err;
        if (Frame_Abort) begin
            w_state_n = IDLE;
        end else if (Bit_Valid) begin
            unique case (r_state)
                IDLE: begin
                    if (Sampled_Bit == ZERO) begin
                        w_start   = 1'b1;
                        w_state_n = DATA;
                    end else begin
                        w_false = 1'b1;
                    end
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_n = r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    w_state_n = STOP;
                end
                STOP: begin
                    w_stop_err_n = Stop_Err | (Sampled_Bit == ZERO);
                    if (!r_stop_2 || r_stop_idx) begin
                        w_end     = 1'b1;
                        w_state_n = IDLE;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    assign w_good = w_end & ~w_stop_err_n & ~Parity_Err;
    assign w_inc  = w_false | (w_end & ~w_good);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_acc      <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_type <= PAR_EVEN;
            r_stop_2   <= 1'b0;
            r_stop_idx <= 1'b0;
            P_Data     <= '0;
            Data_Valid <= 1'b0;
            Start_Err  <= 1'b0;
            Parity_Err <= 1'b0;
            Stop_Err   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            Busy       <= (w_state_n != IDLE);
            Data_Valid <= w_good;
            if (w_start) begin
                r_par_en   <= Par_EN;
                r_par_type <= Par_Type;
                r_stop_2   <= Stop_2;
                r_bit_cnt  <= '0;
                r_acc      <= 1'b0;
                r_stop_idx <= 1'b0;
                Start_Err  <= 1'b0;
                Parity_Err <= 1'b0;
                Stop_Err   <= 1'b0;
            end
            if (w_false) begin
                Start_Err  <= 1'b1;
                Parity_Err <= 1'b0;
                Stop_Err   <= 1'b0;
            end
            if (w_strobe && (r_state == DATA)) begin
                r_shift   <= {Sampled_Bit, r_shift[DATA_WIDTH-1:1]};
                r_acc     <= r_acc ^ Sampled_Bit;
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            if (w_strobe && (r_state == PARITY)) begin
                Parity_Err <= Sampled_Bit ^ r_acc ^ r_par_type;
            end
            if (w_strobe && (r_state == STOP)) begin
                Stop_Err   <= w_stop_err_n;
                r_stop_idx <= 1'b1;
            end
            if (w_good) begin
                P_Data <= r_shift;
            end
        end
    end

    err_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_err_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_inc),
        .clr   (Cnt_Clr),
        .o_cnt (Err_Cnt)
    );

endmodule

// File: tb/tb_uart_frame_check.sv
// Frame-level reference bench for uart_frame_check with
// an 8-bit and a 2-bit error counter instance in parallel.
module tb_uart_frame_check;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Bit_Valid;
    logic       Sampled_Bit;
    logic       Frame_Abort;
    logic       Par_EN;
    logic       Par_Type;
    logic       Stop_2;
    logic       Cnt_Clr;

    logic [7:0] a_pd;
    logic       a_dv;
    logic       a_se;
    logic       a_pe;
    logic       a_so;
    logic       a_busy;
    logic [7:0] a_cnt;

    logic [7:0] b_pd;
    logic       b_dv;
    logic       b_se;
    logic       b_pe;
    logic       b_so;
    logic       b_busy;
    logic [1:0] b_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_pdata;
    logic       m_start;
    logic       m_par;
    logic       m_stop;
    int         m_cnt;

    always #5 CLK = ~CLK;

    uart_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut_a (
        .CLK(CLK), .RST(RST), .Bit_Valid(Bit_Valid),
        .Sampled_Bit(Sampled_Bit), .Frame_Abort(Frame_Abort),
        .Par_EN(Par_EN), .Par_Type(Par_Type), .Stop_2(Stop_2),
        .Cnt_Clr(Cnt_Clr), .P_Data(a_pd), .Data_Valid(a_dv),
        .Start_Err(a_se), .Parity_Err(a_pe), .Stop_Err(a_so),
        .Busy(a_busy), .Err_Cnt(a_cnt)
    );

    uart_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut_b (
        .CLK(CLK), .RST(RST), .Bit_Valid(Bit_Valid),
        .Sampled_Bit(Sampled_Bit), .Frame_Abort(Frame_Abort),
        .Par_EN(Par_EN), .Par_Type(Par_Type), .Stop_2(Stop_2),
        .Cnt_Clr(Cnt_Clr), .P_Data(b_pd), .Data_Valid(b_dv),
        .Start_Err(b_se), .Parity_Err(b_pe), .Stop_Err(b_so),
        .Busy(b_busy), .Err_Cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_all(input string tag, input bit dv,
                             input bit busy);
        check({tag, ".pd"},   32'(a_pd),   32'(m_pdata));
        check({tag, ".dv"},   32'(a_dv),   32'(dv));
        check({tag, ".se"},   32'(a_se),   32'(m_start));
        check({tag, ".pe"},   32'(a_pe),   32'(m_par));
        check({tag, ".so"},   32'(a_so),   32'(m_stop));
        check({tag, ".busy"}, 32'(a_busy), 32'(busy));
        check({tag, ".cnt"},  32'(a_cnt),  32'(sat(m_cnt, 255)));
        check({tag, ".pd2"},  32'(b_pd),   32'(m_pdata));
        check({tag, ".cnt2"}, 32'(b_cnt),  32'(sat(m_cnt, 3)));
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge CLK);
    endtask

    task automatic strobe(input bit b, input bit abort, input bit clr);
        @(negedge CLK);
        Bit_Valid   = 1'b1;
        Sampled_Bit = b;
        Frame_Abort = abort;
        Cnt_Clr     = clr;
        @(negedge CLK);
        Bit_Valid   = 1'b0;
        Sampled_Bit = $urandom_range(0, 1);
        Frame_Abort = 1'b0;
        Cnt_Clr     = 1'b0;
    endtask

    task automatic false_start(input string tag, input bit clr);
        strobe(1'b1, 1'b0, clr);
        m_start = 1'b1;
        m_par   = 1'b0;
        m_stop  = 1'b0;
        m_cnt   = clr ? 0 : m_cnt + 1;
        check_all(tag, 1'b0, 1'b0);
        gap();
    endtask

    // stops[0] is the first stop bit on the line, stops[1] the second.
    task automatic send_frame(input string tag, input logic [7:0] d,
                              input bit pen, input bit ptype,
                              input bit st2, input bit flip_par,
                              input bit [1:0] stops, input int abort_at,
                              input bit clr_end);
        bit pbit;
        bit good;
        int nstop;
        Par_EN   = pen;
        Par_Type = ptype;
        Stop_2   = st2;
        strobe(1'b0, 1'b0, 1'b0);
        m_start = 1'b0;
        m_par   = 1'b0;
        m_stop  = 1'b0;
        check_all({tag, ".start"}, 1'b0, 1'b1);
        Par_EN   = ~pen;
        Par_Type = ~ptype;
        Stop_2   = ~st2;
        for (int i = 0; i < 8; i++) begin
            gap();
            if (i == abort_at) begin
                strobe(d[i], 1'b1, 1'b0);
                check_all({tag, ".abort"}, 1'b0, 1'b0);
                gap();
                return;
            end
            strobe(d[i], 1'b0, 1'b0);
        end
        if (pen) begin
            gap();
            pbit = (^d) ^ ptype ^ flip_par;
            strobe(pbit, 1'b0, 1'b0);
            m_par = flip_par;
        end
        nstop = st2 ? 2 : 1;
        for (int j = 0; j < nstop; j++) begin
            gap();
            strobe(stops[j], 1'b0, clr_end && (j == nstop - 1));
            if (!stops[j]) m_stop = 1'b1;
        end
        good = !m_par && !m_stop;
        if (good) m_pdata = d;
        else m_cnt++;
        if (clr_end) m_cnt = 0;
        check_all({tag, ".end"}, good, 1'b0);
        @(negedge CLK);
        check({tag, ".dv_off"}, 32'(a_dv), 32'(0));
        gap();
    endtask

    initial begin
        RST         = 1'b0;
        Bit_Valid   = 1'b0;
        Sampled_Bit = 1'b1;
        Frame_Abort = 1'b0;
        Par_EN      = 1'b0;
        Par_Type    = 1'b0;
        Stop_2      = 1'b0;
        Cnt_Clr     = 1'b0;
        m_pdata = '0;
        m_start = 1'b0;
        m_par   = 1'b0;
        m_stop  = 1'b0;
        m_cnt   = 0;
        repeat (3) @(negedge CLK);
        check_all("reset", 1'b0, 1'b0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        send_frame("a5", 8'hA5, 1, 0, 0, 0, 2'b11, -1, 0);
        send_frame("a5par", 8'hA5, 1, 0, 0, 1, 2'b11, -1, 0);
        false_start("fs1", 1'b0);
        send_frame("3c", 8'h3C, 0, 0, 0, 0, 2'b11, -1, 0);
        send_frame("st2", 8'h5A, 0, 0, 1, 0, 2'b01, -1, 0);
        send_frame("st2ok", 8'h81, 0, 0, 1, 0, 2'b11, -1, 0);
        send_frame("st1", 8'h96, 0, 1, 0, 0, 2'b10, -1, 0);
        send_frame("abort", 8'h12, 1, 1, 0, 0, 2'b11, 4, 0);
        send_frame("ff", 8'hFF, 1, 1, 0, 0, 2'b11, -1, 0);
        for (int k = 0; k < 5; k++) false_start("sat", 1'b0);
        false_start("satclr", 1'b1);
        send_frame("endclr", 8'h44, 1, 0, 0, 1, 2'b11, -1, 1);

        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                false_start("rfs", ($urandom_range(0, 7) == 0));
            end else begin
                send_frame("rnd", 8'($urandom),
                    bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0),
                    {($urandom_range(0, 6) != 0),
                     ($urandom_range(0, 6) != 0)},
                    (kind == 1) ? int'($urandom_range(0, 7)) : -1,
                    ($urandom_range(0, 15) == 0));
            end
        end

        Par_EN = 1'b1;
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        m_pdata = '0;
        m_start = 1'b0;
        m_par   = 1'b0;
        m_stop  = 1'b0;
        m_cnt   = 0;
        check_all("midrst", 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send_frame("postrst", 8'hC3, 0, 0, 0, 0, 2'b11, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_check.md
# uart_frame_check

Parametrised UART receive frame checker. It supersedes the single-purpose start-bit checker by validating the whole frame in one FSM: the start bit, the data bits with a running parity, an optional parity bit, and one or two stop bits. It sits in UART_RX between the mid-bit data sampler, which supplies Bit_Valid and Sampled_Bit, and the RX output interface. It delivers the parallel data word, per-frame error flags and a saturating error counter.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9), sent LSB first.
- CNT_WIDTH, 8, width of the errored-frame counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- Bit_Valid  in  1  one-cycle strobe; Sampled_Bit holds the decided value of the current bit.
- Sampled_Bit  in  1  sampled line value.
- Frame_Abort  in  1  synchronous abort; FSM returns to IDLE.
- Par_EN  in  1  parity bit present.
- Par_Type  in  1  0 = even, 1 = odd.
- Stop_2  in  1  two stop bits expected.
- Cnt_Clr  in  1  synchronous clear of Err_Cnt.
- P_Data  out  DATA_WIDTH  last good data word.
- Data_Valid  out  1  one-cycle pulse when P_Data updates.
- Start_Err  out  1  start bit sampled high.
- Parity_Err  out  1  parity mismatch in the last frame.
- Stop_Err  out  1  any stop bit sampled low.
- Busy  out  1  high whenever the FSM is not in IDLE.
- Err_Cnt  out  CNT_WIDTH  saturating count of errored frames.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE, Bit_Valid with Sampled_Bit=0:
  - latch Par_EN, Par_Type, Stop_2;
  - clear all three error flags;
  - clear the bit counter and the parity accumulator;
  - go to DATA.
- IDLE, Bit_Valid with Sampled_Bit=1 (false start):
  - Start_Err=1, other flags cleared;
  - Err_Cnt increments;
  - stay in IDLE.
- DATA: each Bit_Valid shifts Sampled_Bit into the MSB of the shift register (right shift, so the LSB-first word lands aligned) and XORs it into the accumulator.
  - After DATA_WIDTH bits, go to PARITY if the latched Par_EN is 1, otherwise go to STOP.
- PARITY: on Bit_Valid, Parity_Err = Sampled_Bit ^ accumulator ^ latched Par_Type; go to STOP.
- STOP: each Bit_Valid with Sampled_Bit=0 sets Stop_Err, which is sticky for the frame.
  - The frame ends after 1 stop bit, or 2 if the latched Stop_2 is 1.
- Frame end, no errors: P_Data loads the shift register, Data_Valid pulses, go to IDLE.
- Frame end, with errors: P_Data holds its old value, Data_Valid stays 0, Err_Cnt increments, go to IDLE.
- Flags hold their value until the next accepted start bit or false start.
- Err_Cnt saturates at 2^CNT_WIDTH-1.
- Config inputs changing mid-frame have no effect until the next start bit.
- Bit_Valid is ignored in no state; every strobe advances the FSM.

## Timing
- All outputs are registered.
- Flags, Data_Valid and Err_Cnt update on the clock edge that samples the relevant Bit_Valid. They are visible one cycle after the strobe.
- Data_Valid is high for exactly one cycle per good frame.
- Frame_Abort and Bit_Valid in the same cycle: abort wins.
  - The bit is ignored and the FSM goes to IDLE.
  - Flags, P_Data and Err_Cnt are unchanged; Data_Valid stays 0.
- Cnt_Clr in the same cycle as an increment: clear wins, Err_Cnt=0.
- Reset values: FSM in IDLE; P_Data=0; Data_Valid=0; Start_Err=0; Parity_Err=0; Stop_Err=0; Busy=0; Err_Cnt=0.
- Reset mid-frame discards the partial frame immediately.
- Back-to-back frames: a start bit may arrive on the strobe directly after the last stop bit. No idle cycle is required.

## Structure
- Shared package uart_rx_pkg holds:
  - the state enum (IDLE/DATA/PARITY/STOP);
  - parity constants PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - bit constants ONE and ZERO.
- One sub-module, err_sat_counter, is parametrised by CNT_WIDTH with inputs inc and clr; clear has priority.
- The bit counter width is $clog2(DATA_WIDTH+1).

## Test plan
- DATA_WIDTH=8, even parity, 1 stop, frame 0,1,0,1,0,0,1,0,1,0,1 -> Data_Valid pulse, P_Data=0xA5, all flags 0, Err_Cnt=0.
- Same frame with parity bit 1 -> Parity_Err=1, no Data_Valid, P_Data unchanged, Err_Cnt=1.
- Start bit sampled 1 -> Start_Err=1, Busy stays 0, Err_Cnt+1. A following valid frame 0x3C clears Start_Err and yields P_Data=0x3C.
- Stop_2=1, no parity, first stop bit 1 and second stop bit 0 -> Stop_Err=1, no Data_Valid. Toggling Stop_2 mid-frame does not change the stop-bit count.
- Frame_Abort asserted with Bit_Valid on data bit 4 -> Busy=0 next cycle, flags and P_Data unchanged; the next frame 0xFF decodes correctly.
- CNT_WIDTH=2: five false starts -> Err_Cnt holds 3. Cnt_Clr asserted together with a sixth false start -> Err_Cnt=0.
